pwm_duty_sequencer: RTL

//   Sequences the duty-cycle input of the PWM generator. Accepts new duty targets over a

---
 rtl/pwm_duty_sequencer_if.sv | 22 ++
 rtl/pwm_duty_sequencer.sv | 128 ++++++++++++
 2 files changed

// File: rtl/pwm_duty_sequencer_if.sv
// Command handshake between the control/register side and the duty sequencer.
interface pwm_duty_sequencer_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_duty;

  modport master (
    output cmd_valid,
    output cmd_duty,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_duty,
    output cmd_ready
  );

endinterface

// File: rtl/pwm_duty_sequencer.sv
// Slews the PWM generator duty toward a commanded target, one step of at most
// STEP per PWM period, changing duty only on the generator's period boundary.
// Optional feature macro: PWM_SEQ_DONE_EN adds a one-cycle `done` pulse when a
// ramp reaches its target.
module pwm_duty_sequencer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned STEP  = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  period_end,
  pwm_duty_sequencer_if.slave   cmd,
  output logic [WIDTH-1:0]      duty,
`ifdef PWM_SEQ_DONE_EN
  output logic                  done,
`endif
  output logic                  busy
);

  localparam int unsigned DW = WIDTH + 1;
  localparam logic [DW-1:0]    STEP_W = DW'(STEP);
  localparam logic [WIDTH-1:0] STEP_D = WIDTH'(STEP);

  // Reject a step size that can never move the duty or exceeds its range.
  if (STEP == 0 || 64'(STEP) > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_step
    $fatal(1, "pwm_duty_sequencer: STEP out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_RAMP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] duty_d;
  logic [DW-1:0]    diff;
  logic             up;
  logic             accept;
`ifdef PWM_SEQ_DONE_EN
  logic             done_d;
`endif

  // Ready only while holding a settled duty; idle and ramping refuse commands.
  assign cmd.cmd_ready = enable && (state_q == S_HOLD);
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign busy          = (state_q == S_RAMP);

  // Distance to target, one bit wider so the subtraction never wraps.
  always_comb begin
    up   = (target_q > duty);
    diff = up ? (DW'(target_q) - DW'(duty)) : (DW'(duty) - DW'(target_q));
  end

  // Next-state, duty and target decisions.
  always_comb begin
    state_d  = state_q;
    duty_d   = duty;
    target_d = target_q;
    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (!enable) begin
          if (period_end) begin
            state_d  = S_IDLE;
            duty_d   = '0;
            target_d = '0;
          end
        end else if (accept) begin
          target_d = cmd.cmd_duty;
          if (cmd.cmd_duty != duty) state_d = S_RAMP;
        end
      end
      S_RAMP: begin
        if (!enable) begin
          if (period_end) begin
            state_d  = S_IDLE;
            duty_d   = '0;
            target_d = '0;
          end
        end else if (period_end) begin
          if (diff <= STEP_W) begin
            duty_d  = target_q;
            state_d = S_HOLD;
          end else if (up) begin
            duty_d = duty + STEP_D;
          end else begin
            duty_d = duty - STEP_D;
          end
        end
      end
      default: begin
        state_d  = S_IDLE;
        duty_d   = '0;
        target_d = '0;
      end
    endcase
`ifdef PWM_SEQ_DONE_EN
    done_d = (state_q == S_RAMP) && (state_d == S_HOLD);
`endif
  end

  // State, duty and target registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      duty     <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      duty     <= duty_d;
      target_q <= target_d;
    end
  end

`ifdef PWM_SEQ_DONE_EN
  // One-cycle pulse registered with the ramp-to-hold transition.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) done <= 1'b0;
    else          done <= done_d;
  end
`endif

endmodule
